// File: rtl/joker_cmd_pkg.sv
// Shared types and constants for the joker command dispatcher: FSM state
// encoding, error reply reason codes and well-known command codes.
package joker_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_MATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5,
    ST_COMMIT = 3'd6,
    ST_ARM    = 3'd7
  } state_t;

  // Second byte of an error reply
  typedef enum logic [7:0] {
    ERR_NONE    = 8'h00,
    ERR_UNKNOWN = 8'h01,
    ERR_TIMEOUT = 8'h02
  } err_reason_t;

  // Code 0x00 is reserved so an unconfigured channel can never be selected
  localparam logic [7:0] J_CMD_NONE      = 8'h00;
  localparam logic [7:0] J_CMD_ERR_REPLY = 8'hFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/joker_cmd_dispatch_if.sv
// USB-side endpoint bus of the dispatcher: EP2 OUT read/arm port and
// EP1 IN write/commit port. master = dispatcher, slave = endpoint logic.
interface joker_cmd_dispatch_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 10
);
  logic              buf_out_hasdata;
  logic [LEN_W-1:0]  buf_out_len;
  logic [7:0]        buf_out_q;
  logic [ADDR_W-1:0] buf_out_addr;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic              usb_in_ready;
  logic [ADDR_W-1:0] usb_in_addr;
  logic [7:0]        usb_in_data;
  logic              usb_in_wren;
  logic              usb_in_commit;
  logic [ADDR_W-1:0] usb_in_commit_len;
  logic              usb_in_commit_ack;

  modport master (
    input  buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack,
           usb_in_ready, usb_in_commit_ack,
    output buf_out_addr, buf_out_arm, usb_in_addr, usb_in_data,
           usb_in_wren, usb_in_commit, usb_in_commit_len
  );

  modport slave (
    output buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack,
           usb_in_ready, usb_in_commit_ack,
    input  buf_out_addr, buf_out_arm, usb_in_addr, usb_in_data,
           usb_in_wren, usb_in_commit, usb_in_commit_len
  );
endinterface

// File: rtl/joker_cmd_mux.sv
// Routes the selected handler channel's EP ports (and its done/reply length)
// onto the shared USB side; falls back to the dispatcher's own signals.
module joker_cmd_mux #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 11,
  parameter int SEL_W  = 2
) (
  input  logic                     route,
  input  logic [SEL_W-1:0]         sel,
  input  logic [ADDR_W-1:0]        int_buf_out_addr,
  input  logic [ADDR_W-1:0]        int_usb_in_addr,
  input  logic [7:0]               int_usb_in_data,
  input  logic                     int_usb_in_wren,
  input  logic [N_CH-1:0]          ch_done,
  input  logic [ADDR_W*N_CH-1:0]   ch_reply_len,
  input  logic [ADDR_W*N_CH-1:0]   ch_buf_out_addr,
  input  logic [ADDR_W*N_CH-1:0]   ch_usb_in_addr,
  input  logic [8*N_CH-1:0]        ch_usb_in_data,
  input  logic [N_CH-1:0]          ch_usb_in_wren,
  output logic                     sel_done,
  output logic [ADDR_W-1:0]        sel_reply_len,
  output logic [ADDR_W-1:0]        buf_out_addr,
  output logic [ADDR_W-1:0]        usb_in_addr,
  output logic [7:0]               usb_in_data,
  output logic                     usb_in_wren
);

  logic [ADDR_W-1:0] reply_len_a [N_CH];
  logic [ADDR_W-1:0] out_addr_a  [N_CH];
  logic [ADDR_W-1:0] in_addr_a   [N_CH];
  logic [7:0]        in_data_a   [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign reply_len_a[gi] = ch_reply_len[gi*ADDR_W +: ADDR_W];
    assign out_addr_a[gi]  = ch_buf_out_addr[gi*ADDR_W +: ADDR_W];
    assign in_addr_a[gi]   = ch_usb_in_addr[gi*ADDR_W +: ADDR_W];
    assign in_data_a[gi]   = ch_usb_in_data[gi*8 +: 8];
  end

  always_comb begin
    sel_done      = 1'b0;
    sel_reply_len = '0;
    buf_out_addr  = int_buf_out_addr;
    usb_in_addr   = int_usb_in_addr;
    usb_in_data   = int_usb_in_data;
    usb_in_wren   = int_usb_in_wren;
    if (route) begin
      sel_done      = ch_done[sel];
      sel_reply_len = reply_len_a[sel];
      buf_out_addr  = out_addr_a[sel];
      usb_in_addr   = in_addr_a[sel];
      usb_in_data   = in_data_a[sel];
      usb_in_wren   = ch_usb_in_wren[sel];
    end
  end

endmodule

// File: rtl/joker_cmd_dispatch.sv
// Command dispatcher: reads byte 0 of an EP2 OUT buffer, hands the command to
// the handler channel claiming that code, and replies with an error otherwise.
module joker_cmd_dispatch
  import joker_cmd_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          ADDR_W   = 11,
  parameter int          LEN_W    = 10,
  parameter int          READ_LAT = 3,
  parameter int          TIMEOUT  = 2000000,
  parameter logic [7:0]  ERR_CODE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  joker_cmd_dispatch_if.master   usb,
  input  logic [8*N_CH-1:0]      ch_code,
  output logic [N_CH-1:0]        ch_start,
  output logic [N_CH-1:0]        ch_abort,
  output logic [7:0]             ch_cmd,
  input  logic [N_CH-1:0]        ch_done,
  input  logic [ADDR_W*N_CH-1:0] ch_reply_len,
  input  logic [ADDR_W*N_CH-1:0] ch_buf_out_addr,
  input  logic [ADDR_W*N_CH-1:0] ch_usb_in_addr,
  input  logic [8*N_CH-1:0]      ch_usb_in_data,
  input  logic [N_CH-1:0]        ch_usb_in_wren,
  output logic [15:0]            cmd_count,
  output logic [15:0]            err_count
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t            state_reg, state_next;
  logic [31:0]       cnt_reg, cnt_next;
  logic [7:0]        cmd_reg, cmd_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic              sel_valid_reg, sel_valid_next;
  err_reason_t       reason_reg, reason_next;
  logic [ADDR_W-1:0] commit_len_reg, commit_len_next;
  logic [15:0]       cmd_count_reg, cmd_count_next;
  logic [15:0]       err_count_reg, err_count_next;
  logic [N_CH-1:0]   start_reg, start_next;
  logic [N_CH-1:0]   abort_reg, abort_next;
  logic [ADDR_W-1:0] int_addr_reg, int_addr_next;
  logic [7:0]        int_data_reg, int_data_next;
  logic              int_wren_reg, int_wren_next;
  logic              commit_ack_d_reg, arm_ack_d_reg;

  logic              commit_fall, arm_fall;
  logic              match_found;
  logic [SEL_W-1:0]  match_idx;
  logic              sel_done;
  logic [ADDR_W-1:0] sel_reply_len;
  logic [ADDR_W-1:0] mux_buf_out_addr, mux_usb_in_addr;
  logic [7:0]        mux_usb_in_data;
  logic              mux_usb_in_wren;

  assign commit_fall = commit_ack_d_reg & ~usb.usb_in_commit_ack;
  assign arm_fall    = arm_ack_d_reg & ~usb.buf_out_arm_ack;

  // Descending scan so the lowest-numbered claiming channel wins
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cmd_reg != J_CMD_NONE && ch_code[i*8 +: 8] == cmd_reg) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  joker_cmd_mux #(
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .route            (state_reg == ST_RUN && sel_valid_reg),
    .sel              (sel_reg),
    .int_buf_out_addr ('0),
    .int_usb_in_addr  (int_addr_reg),
    .int_usb_in_data  (int_data_reg),
    .int_usb_in_wren  (int_wren_reg),
    .ch_done          (ch_done),
    .ch_reply_len     (ch_reply_len),
    .ch_buf_out_addr  (ch_buf_out_addr),
    .ch_usb_in_addr   (ch_usb_in_addr),
    .ch_usb_in_data   (ch_usb_in_data),
    .ch_usb_in_wren   (ch_usb_in_wren),
    .sel_done         (sel_done),
    .sel_reply_len    (sel_reply_len),
    .buf_out_addr     (mux_buf_out_addr),
    .usb_in_addr      (mux_usb_in_addr),
    .usb_in_data      (mux_usb_in_data),
    .usb_in_wren      (mux_usb_in_wren)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cmd_next        = cmd_reg;
    sel_next        = sel_reg;
    sel_valid_next  = sel_valid_reg;
    reason_next     = reason_reg;
    commit_len_next = commit_len_reg;
    cmd_count_next  = cmd_count_reg;
    err_count_next  = err_count_reg;
    start_next      = '0;
    abort_next      = '0;
    int_addr_next   = '0;
    int_data_next   = '0;
    int_wren_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (usb.buf_out_hasdata)
          state_next = (usb.buf_out_len == '0) ? ST_ARM : ST_READ;
      end
      ST_READ: begin
        cnt_next = cnt_reg + 32'd1;
        if (cnt_reg == 32'(READ_LAT)) begin
          cmd_next   = usb.buf_out_q;
          state_next = ST_MATCH;
        end
      end
      ST_MATCH: begin
        if (match_found) begin
          sel_next       = match_idx;
          sel_valid_next = 1'b1;
          state_next     = ST_START;
        end else begin
          reason_next = ERR_UNKNOWN;
          state_next  = ST_ERR;
        end
      end
      ST_START: begin
        if (usb.usb_in_ready) begin
          start_next[sel_reg] = 1'b1;
          cmd_count_next      = sat_inc16(cmd_count_reg);
          state_next          = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_next = cnt_reg + 32'd1;
        if (sel_done) begin
          commit_len_next = sel_reply_len;
          state_next      = (sel_reply_len != '0) ? ST_COMMIT : ST_ARM;
        end else if (cnt_reg == 32'(TIMEOUT)) begin
          abort_next[sel_reg] = 1'b1;
          reason_next         = ERR_TIMEOUT;
          state_next          = ST_ERR;
        end
      end
      // cnt doubles as the byte index of the two-byte error reply
      ST_ERR: begin
        if (cnt_reg == 32'd0) begin
          if (usb.usb_in_ready) begin
            int_wren_next = 1'b1;
            int_addr_next = '0;
            int_data_next = ERR_CODE;
            cnt_next      = 32'd1;
          end
        end else if (cnt_reg == 32'd1) begin
          int_wren_next = 1'b1;
          int_addr_next = ADDR_W'(1);
          int_data_next = reason_reg;
          cnt_next      = 32'd2;
        end else begin
          commit_len_next = ADDR_W'(2);
          err_count_next  = sat_inc16(err_count_reg);
          state_next      = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (commit_fall) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (arm_fall) begin
          cmd_next       = '0;
          sel_next       = '0;
          sel_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      cmd_reg          <= '0;
      sel_reg          <= '0;
      sel_valid_reg    <= 1'b0;
      reason_reg       <= ERR_NONE;
      commit_len_reg   <= '0;
      cmd_count_reg    <= '0;
      err_count_reg    <= '0;
      start_reg        <= '0;
      abort_reg        <= '0;
      int_addr_reg     <= '0;
      int_data_reg     <= '0;
      int_wren_reg     <= 1'b0;
      commit_ack_d_reg <= 1'b0;
      arm_ack_d_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      cmd_reg          <= cmd_next;
      sel_reg          <= sel_next;
      sel_valid_reg    <= sel_valid_next;
      reason_reg       <= reason_next;
      commit_len_reg   <= commit_len_next;
      cmd_count_reg    <= cmd_count_next;
      err_count_reg    <= err_count_next;
      start_reg        <= start_next;
      abort_reg        <= abort_next;
      int_addr_reg     <= int_addr_next;
      int_data_reg     <= int_data_next;
      int_wren_reg     <= int_wren_next;
      commit_ack_d_reg <= usb.usb_in_commit_ack;
      arm_ack_d_reg    <= usb.buf_out_arm_ack;
    end
  end

  assign usb.buf_out_addr      = mux_buf_out_addr;
  assign usb.usb_in_addr       = mux_usb_in_addr;
  assign usb.usb_in_data       = mux_usb_in_data;
  assign usb.usb_in_wren       = mux_usb_in_wren;
  assign usb.usb_in_commit     = (state_reg == ST_COMMIT);
  assign usb.buf_out_arm       = (state_reg == ST_ARM);
  assign usb.usb_in_commit_len = commit_len_reg;
  assign ch_start              = start_reg;
  assign ch_abort              = abort_reg;
  assign ch_cmd                = cmd_reg;
  assign cmd_count             = cmd_count_reg;
  assign err_count             = err_count_reg;

endmodule

// File: tb/tb_joker_cmd_dispatch.sv
// Directed bench for joker_cmd_dispatch: normal dispatch, unknown code,
// timeout, duplicate codes, EP1 backpressure, empty buffer and reset in RUN.
module tb_joker_cmd_dispatch;

  localparam int N_CH = 4;
  localparam int AW   = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [8*N_CH-1:0] ch_code;
  logic [N_CH-1:0]   ch_start, ch_abort, ch_done, ch_usb_in_wren;
  logic [7:0]        ch_cmd;
  logic [AW*N_CH-1:0] ch_reply_len, ch_buf_out_addr, ch_usb_in_addr;
  logic [8*N_CH-1:0] ch_usb_in_data;
  logic [15:0]       cmd_count, err_count;

  int checks = 0;
  int failures = 0;

  joker_cmd_dispatch_if #(.ADDR_W(AW), .LEN_W(10)) bus ();

  joker_cmd_dispatch #(
    .N_CH(N_CH), .ADDR_W(AW), .LEN_W(10), .READ_LAT(3),
    .TIMEOUT(1000), .ERR_CODE(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .usb(bus), .ch_code(ch_code),
    .ch_start(ch_start), .ch_abort(ch_abort), .ch_cmd(ch_cmd),
    .ch_done(ch_done), .ch_reply_len(ch_reply_len),
    .ch_buf_out_addr(ch_buf_out_addr), .ch_usb_in_addr(ch_usb_in_addr),
    .ch_usb_in_data(ch_usb_in_data), .ch_usb_in_wren(ch_usb_in_wren),
    .cmd_count(cmd_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // EP2 OUT buffer with a 3-cycle read pipeline, EP1 IN capture, and monitors
  logic [7:0] ep2_mem [16];
  logic [7:0] ep1_mem [16];
  logic [7:0] q_pipe  [3];
  int start_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    q_pipe[0] <= ep2_mem[bus.buf_out_addr[3:0]];
    q_pipe[1] <= q_pipe[0];
    q_pipe[2] <= q_pipe[1];
    if (ch_start != '0) start_cnt <= start_cnt + 1;
    if (bus.usb_in_wren) begin
      ep1_mem[bus.usb_in_addr[3:0]] <= bus.usb_in_data;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign bus.buf_out_q = q_pipe[2];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input logic [3:0] exp);
    int n = 0;
    while (ch_start == '0 && n < 100) begin tick; n++; end
    check(tag, 32'(ch_start), 32'(exp));
  endtask

  task automatic ack_commit(input string tag, input logic [10:0] exp_len);
    int n = 0;
    while (bus.usb_in_commit !== 1'b1 && n < 100) begin tick; n++; end
    check({tag, "_commit"}, 32'(bus.usb_in_commit), 32'd1);
    check({tag, "_commit_len"}, 32'(bus.usb_in_commit_len), 32'(exp_len));
    repeat (3) tick;
    check({tag, "_commit_hold"}, 32'(bus.usb_in_commit), 32'd1);
    bus.usb_in_commit_ack = 1'b1; tick;
    bus.usb_in_commit_ack = 1'b0; tick;
    check({tag, "_commit_drop"}, 32'(bus.usb_in_commit), 32'd0);
  endtask

  task automatic ack_arm(input string tag);
    int n = 0;
    while (bus.buf_out_arm !== 1'b1 && n < 100) begin tick; n++; end
    check({tag, "_arm"}, 32'(bus.buf_out_arm), 32'd1);
    bus.buf_out_hasdata = 1'b0;
    repeat (2) tick;
    check({tag, "_arm_hold"}, 32'(bus.buf_out_arm), 32'd1);
    bus.buf_out_arm_ack = 1'b1; tick;
    bus.buf_out_arm_ack = 1'b0; tick;
    check({tag, "_arm_drop"}, 32'(bus.buf_out_arm), 32'd0);
  endtask

  task automatic load_cmd(input logic [7:0] b0, input logic [9:0] len);
    ep2_mem[0] = b0;
    bus.buf_out_len = len;
    bus.buf_out_hasdata = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, w0, n;
    for (int i = 0; i < 16; i++) ep2_mem[i] = 8'h00;
    ep2_mem[5] = 8'h5A;
    reset = 1'b1;
    ch_code = 32'h04030201;
    ch_done = '0; ch_reply_len = '0; ch_buf_out_addr = '0;
    ch_usb_in_addr = '0; ch_usb_in_data = '0; ch_usb_in_wren = '0;
    bus.buf_out_hasdata = 1'b0; bus.buf_out_len = '0;
    bus.buf_out_arm_ack = 1'b0; bus.usb_in_ready = 1'b1;
    bus.usb_in_commit_ack = 1'b0;
    repeat (4) tick;
    check("rst_start", 32'(ch_start), 32'd0);
    check("rst_cmd", 32'(ch_cmd), 32'd0);
    check("rst_commit", 32'(bus.usb_in_commit), 32'd0);
    check("rst_arm", 32'(bus.buf_out_arm), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick;

    // 1: byte0=03 -> channel 2, two-byte reply
    load_cmd(8'h03, 10'd4);
    wait_start("t1_start", 4'b0100);
    check("t1_ch_cmd", 32'(ch_cmd), 32'h03);
    tick;
    check("t1_start_pulse", 32'(ch_start), 32'd0);
    check("t1_cmd_count", 32'(cmd_count), 32'd1);
    ch_buf_out_addr[22 +: 11] = 11'd5;
    ch_usb_in_addr[22 +: 11] = 11'd0; ch_usb_in_data[16 +: 8] = 8'hAA;
    ch_usb_in_wren[2] = 1'b1;
    #1;
    check("t1_mux_out_addr", 32'(bus.buf_out_addr), 32'd5);
    check("t1_mux_wren", 32'(bus.usb_in_wren), 32'd1);
    check("t1_mux_data", 32'(bus.usb_in_data), 32'hAA);
    tick;
    ch_usb_in_addr[22 +: 11] = 11'd1; ch_usb_in_data[16 +: 8] = 8'hBB;
    tick;
    ch_usb_in_wren[2] = 1'b0; ch_buf_out_addr = '0;
    ch_done[2] = 1'b1; ch_reply_len[22 +: 11] = 11'd2;
    tick;
    ch_done[2] = 1'b0;
    ack_commit("t1", 11'd2);
    check("t1_ep1_b0", 32'(ep1_mem[0]), 32'hAA);
    check("t1_ep1_b1", 32'(ep1_mem[1]), 32'hBB);
    ack_arm("t1");

    // 2: unmapped code -> error reply FF 01
    s0 = start_cnt; w0 = wr_cnt;
    load_cmd(8'h55, 10'd4);
    ack_commit("t2", 11'd2);
    check("t2_ep1_b0", 32'(ep1_mem[0]), 32'hFF);
    check("t2_ep1_b1", 32'(ep1_mem[1]), 32'h01);
    check("t2_writes", 32'(wr_cnt - w0), 32'd2);
    check("t2_no_start", 32'(start_cnt - s0), 32'd0);
    check("t2_err_count", 32'(err_count), 32'd1);
    check("t2_cmd_count", 32'(cmd_count), 32'd1);
    ack_arm("t2");

    // 3: channel 0 never finishes -> abort, reply FF 02; late done ignored
    load_cmd(8'h01, 10'd4);
    wait_start("t3_start", 4'b0001);
    n = 0;
    while (ch_abort == '0 && n < 1100) begin tick; n++; end
    check("t3_abort", 32'(ch_abort), 32'd1);
    // cnt hits 1000 in RUN cycle 1000; the registered pulse shows one cycle later
    check("t3_abort_cycle", 32'(n), 32'd1001);
    w0 = wr_cnt;
    tick;
    check("t3_abort_pulse", 32'(ch_abort), 32'd0);
    ch_done[0] = 1'b1; ch_reply_len[0 +: 11] = 11'd7;
    ack_commit("t3", 11'd2);
    ch_done[0] = 1'b0; ch_reply_len[0 +: 11] = 11'd0;
    check("t3_ep1_b1", 32'(ep1_mem[1]), 32'h02);
    check("t3_writes", 32'(wr_cnt - w0), 32'd2);
    check("t3_err_count", 32'(err_count), 32'd2);
    ack_arm("t3");
    check("t3_cmd_count", 32'(cmd_count), 32'd2);

    // 4: code 07 on channels 1 and 3 -> channel 1; zero-length reply
    ch_code = 32'h07030701;
    s0 = start_cnt;
    load_cmd(8'h07, 10'd4);
    wait_start("t4_start", 4'b0010);
    ch_done[3] = 1'b1; ch_reply_len[33 +: 11] = 11'd3;
    repeat (2) tick;
    ch_done[3] = 1'b0;
    check("t4_other_done_commit", 32'(bus.usb_in_commit), 32'd0);
    check("t4_other_done_arm", 32'(bus.buf_out_arm), 32'd0);
    ch_done[1] = 1'b1; ch_reply_len[11 +: 11] = 11'd0;
    tick;
    ch_done[1] = 1'b0;
    check("t4_arm_direct", 32'(bus.buf_out_arm), 32'd1);
    check("t4_no_commit", 32'(bus.usb_in_commit), 32'd0);
    ack_arm("t4");
    check("t4_one_start", 32'(start_cnt - s0), 32'd1);
    check("t4_cmd_count", 32'(cmd_count), 32'd3);

    // 5: EP1 not ready for 50 cycles delays the start
    bus.usb_in_ready = 1'b0;
    s0 = start_cnt; w0 = wr_cnt;
    load_cmd(8'h01, 10'd4);
    repeat (50) tick;
    check("t5_no_start", 32'(start_cnt - s0), 32'd0);
    check("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    bus.usb_in_ready = 1'b1;
    wait_start("t5_start", 4'b0001);
    ch_done[0] = 1'b1;
    tick;
    ch_done[0] = 1'b0;
    ack_arm("t5");
    check("t5_cmd_count", 32'(cmd_count), 32'd4);

    // 6: empty buffer -> straight to arm, nothing counted
    s0 = start_cnt; w0 = wr_cnt;
    load_cmd(8'h03, 10'd0);
    ack_arm("t6");
    check("t6_no_start", 32'(start_cnt - s0), 32'd0);
    check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    check("t6_cmd_count", 32'(cmd_count), 32'd4);
    check("t6_err_count", 32'(err_count), 32'd2);

    // 7: code 00 never matches even when a channel claims it
    ch_code = 32'h07030700;
    s0 = start_cnt;
    load_cmd(8'h00, 10'd4);
    ack_commit("t7", 11'd2);
    check("t7_ep1_b1", 32'(ep1_mem[1]), 32'h01);
    check("t7_no_start", 32'(start_cnt - s0), 32'd0);
    check("t7_err_count", 32'(err_count), 32'd3);
    ack_arm("t7");

    // 8: reset while a handler runs, then a clean redispatch
    ch_code = 32'h04030201;
    load_cmd(8'h03, 10'd4);
    wait_start("t8_start", 4'b0100);
    repeat (5) tick;
    reset = 1'b1;
    tick;
    check("t8_rst_cmd", 32'(ch_cmd), 32'd0);
    check("t8_rst_cmd_count", 32'(cmd_count), 32'd0);
    check("t8_rst_err_count", 32'(err_count), 32'd0);
    check("t8_rst_commit", 32'(bus.usb_in_commit), 32'd0);
    check("t8_rst_commit_len", 32'(bus.usb_in_commit_len), 32'd0);
    check("t8_rst_arm", 32'(bus.buf_out_arm), 32'd0);
    check("t8_rst_wren", 32'(bus.usb_in_wren), 32'd0);
    reset = 1'b0;
    wait_start("t8_restart", 4'b0100);
    tick;
    check("t8_cmd_count", 32'(cmd_count), 32'd1);
    ch_done[2] = 1'b1; ch_reply_len[22 +: 11] = 11'd0;
    tick;
    ch_done[2] = 1'b0;
    ack_arm("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
